mem_arbiter: RTL and testbench

- Sequences the single external 16-bit SRAM and shares it between two requesters: port A (CPU fetch/load/store path) and port B (program loader / debug port).
- Performs one word transaction at a time with a fixed setup phase and a parameterised wait-state phase, then returns a one-cycle ack to the winning requester.
- Arbitration is round-robin.
- Sits between the CPU top level and the SRAM pins. The top level turns Data_drv/Data_oe into the inout Data bus through a tristate_buffer.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter and sequencer for a single external 16-bit
//            SRAM shared by port A (CPU) and port B (loader/debug). One word
//            transaction at a time: SETUP (1 cycle), ACCESS (WAIT_CYCLES
//            cycles), DONE (1 cycle, ack to the winning port), then IDLE.
// Ports    : Clk, Reset (async, active-low)
//            A_/B_ req, we, addr[19:0], wdata[15:0] -> ack, rdata[15:0]
//            ADDR[19:0], Data_in[15:0], Data_drv[15:0], Data_oe
//            CE, UB, LB, OE, WE (active-low SRAM controls), busy
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        A_req,
    input  logic        A_we,
    input  logic [19:0] A_addr,
    input  logic [15:0] A_wdata,
    output logic        A_ack,
    output logic [15:0] A_rdata,
    input  logic        B_req,
    input  logic        B_we,
    input  logic [19:0] B_addr,
    input  logic [15:0] B_wdata,
    output logic        B_ack,
    output logic [15:0] B_rdata,
    output logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_drv,
    output logic        Data_oe,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic       c_PORT_A   = 1'b0;
    localparam logic       c_PORT_B   = 1'b1;

    state_t      state_q;
    logic        last_grant_q;
    logic        grant_q;
    logic        we_q;
    logic [3:0]  cnt_q;

    logic        grant_d;
    logic        we_d;
    logic [19:0] addr_d;
    logic [15:0] wdata_d;

    // Winner selection; only consumed in IDLE, so it never reaches a pin
    // without passing through a register first.
    always_comb begin
        grant_d = c_PORT_A;
        if (B_req && (!A_req || (last_grant_q == c_PORT_A))) begin
            grant_d = c_PORT_B;
        end
        we_d    = grant_d ? B_we    : A_we;
        addr_d  = grant_d ? B_addr  : A_addr;
        wdata_d = grant_d ? B_wdata : A_wdata;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= c_PORT_B;
            grant_q      <= c_PORT_A;
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            ADDR         <= 20'd0;
            Data_drv     <= 16'd0;
            Data_oe      <= 1'b0;
            CE           <= 1'b1;
            UB           <= 1'b1;
            LB           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            A_ack        <= 1'b0;
            B_ack        <= 1'b0;
            A_rdata      <= 16'd0;
            B_rdata      <= 16'd0;
            busy         <= 1'b0;
        end else begin
            A_ack <= 1'b0;
            B_ack <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (A_req || B_req) begin
                        // ADDR/Data_drv double as the latched request copy,
                        // so later changes on the request inputs are ignored.
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= we_d;
                        ADDR         <= addr_d;
                        Data_drv     <= wdata_d;
                        Data_oe      <= we_d;
                        CE           <= 1'b0;
                        UB           <= 1'b0;
                        LB           <= 1'b0;
                        OE           <= we_d;
                        WE           <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    WE      <= ~we_q;
                    cnt_q   <= c_CNT_LOAD;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (!we_q) begin
                            if (grant_q == c_PORT_B) begin
                                B_rdata <= Data_in;
                            end else begin
                                A_rdata <= Data_in;
                            end
                        end
                        // WE rises and Data_oe falls on the same edge, so
                        // write data stays on the bus until WE is released.
                        CE      <= 1'b1;
                        UB      <= 1'b1;
                        LB      <= 1'b1;
                        OE      <= 1'b1;
                        WE      <= 1'b1;
                        Data_oe <= 1'b0;
                        if (grant_q == c_PORT_B) begin
                            B_ack <= 1'b1;
                        end else begin
                            A_ack <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter. Three instances with
//            WAIT_CYCLES = 2, 1, 15 share clock and reset; each has its own
//            requesters and a small SRAM model. Expected acks (port, cycle,
//            read data) are queued when requests are driven and popped when
//            an ack appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_N = 3;

    function automatic int wc_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    int   cyc   = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    logic        A_req   [c_N];
    logic        A_we    [c_N];
    logic [19:0] A_addr  [c_N];
    logic [15:0] A_wdata [c_N];
    logic        A_ack   [c_N];
    logic [15:0] A_rdata [c_N];
    logic        B_req   [c_N];
    logic        B_we    [c_N];
    logic [19:0] B_addr  [c_N];
    logic [15:0] B_wdata [c_N];
    logic        B_ack   [c_N];
    logic [15:0] B_rdata [c_N];
    logic [19:0] ADDR    [c_N];
    logic [15:0] Data_in [c_N];
    logic [15:0] Data_drv[c_N];
    logic        Data_oe [c_N];
    logic        CE      [c_N];
    logic        UB      [c_N];
    logic        LB      [c_N];
    logic        OE      [c_N];
    logic        WE      [c_N];
    logic        busy    [c_N];

    for (genvar gi = 0; gi < c_N; gi++) begin : g_dut
        mem_arbiter #(.WAIT_CYCLES(wc_of(gi))) u_dut (
            .Clk(Clk), .Reset(Reset),
            .A_req(A_req[gi]), .A_we(A_we[gi]), .A_addr(A_addr[gi]),
            .A_wdata(A_wdata[gi]), .A_ack(A_ack[gi]), .A_rdata(A_rdata[gi]),
            .B_req(B_req[gi]), .B_we(B_we[gi]), .B_addr(B_addr[gi]),
            .B_wdata(B_wdata[gi]), .B_ack(B_ack[gi]), .B_rdata(B_rdata[gi]),
            .ADDR(ADDR[gi]), .Data_in(Data_in[gi]), .Data_drv(Data_drv[gi]),
            .Data_oe(Data_oe[gi]), .CE(CE[gi]), .UB(UB[gi]), .LB(LB[gi]),
            .OE(OE[gi]), .WE(WE[gi]), .busy(busy[gi])
        );
    end

    typedef struct {
        int          inst;
        bit          port;
        bit          rd;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
    } op_t;

    exp_t        sbq[$];
    op_t         qa[$];
    op_t         qb[$];
    logic [15:0] mdl_rd [c_N][2];
    logic [15:0] mem    [c_N][4096];
    int          ce_run [c_N];
    int          we_run [c_N];
    int          total = 0;
    int          bad   = 0;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SRAM model: writes while CE and WE are low, reads only when enabled.
    always @(negedge Clk) begin
        for (int i = 0; i < c_N; i++) begin
            if (!Reset) begin
                mem[i][12'h123] <= 16'hBEEF;
            end else if (!CE[i] && !WE[i]) begin
                mem[i][ADDR[i][11:0]] <= Data_drv[i];
            end
            Data_in[i] <= (!CE[i] && !OE[i]) ? mem[i][ADDR[i][11:0]] : 16'h0BAD;
        end
    end

    task automatic pop_check(int i, bit p);
        exp_t e;
        check_val("ack_has_exp", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val("ack_inst", e.inst, i);
            check_val("ack_port", {31'd0, p}, {31'd0, e.port});
            check_val("ack_cycle", cyc, e.cyc);
            check_val("done_ce", CE[i], 1'b1);
            check_val("done_we", WE[i], 1'b1);
            check_val("done_data_oe", Data_oe[i], 1'b0);
            check_val("done_busy", busy[i], 1'b1);
            check_val("ack_other", p ? A_ack[i] : B_ack[i], 1'b0);
            if (e.rd) mdl_rd[i][p] = e.rdata;
        end
        check_val("a_rdata", A_rdata[i], mdl_rd[i][0]);
        check_val("b_rdata", B_rdata[i], mdl_rd[i][1]);
    endtask

    // Bus monitor: window lengths, control levels against the active
    // transaction, and ack scoreboard.
    always @(negedge Clk) begin
        for (int i = 0; i < c_N; i++) begin
            if (!Reset) begin
                ce_run[i] <= 0;
                we_run[i] <= 0;
            end else begin
                if (!CE[i]) begin
                    ce_run[i] <= ce_run[i] + 1;
                end else if (ce_run[i] != 0) begin
                    check_val("ce_window", ce_run[i], 1 + wc_of(i));
                    ce_run[i] <= 0;
                end
                if (!WE[i]) begin
                    we_run[i] <= we_run[i] + 1;
                end else if (we_run[i] != 0) begin
                    check_val("we_window", we_run[i], wc_of(i));
                    we_run[i] <= 0;
                end
                if (!CE[i] && sbq.size() > 0 && sbq[0].inst == i) begin
                    check_val("bus_addr", ADDR[i], sbq[0].addr);
                    check_val("bus_oe", OE[i], !sbq[0].rd);
                    check_val("bus_data_oe", Data_oe[i], !sbq[0].rd);
                    check_val("bus_ublb", {UB[i], LB[i]}, 2'b00);
                    if (sbq[0].rd) check_val("bus_we_rd", WE[i], 1'b1);
                    else           check_val("bus_wdata", Data_drv[i], sbq[0].wdata);
                end
                if (A_ack[i]) pop_check(i, 1'b0);
                if (B_ack[i]) pop_check(i, 1'b1);
            end
        end
    end

    task automatic check_idle(int i, string tag);
        check_val({tag, "_ctl"}, {CE[i], UB[i], LB[i], OE[i], WE[i]}, 5'b11111);
        check_val({tag, "_data_oe"}, Data_oe[i], 1'b0);
        check_val({tag, "_addr"}, ADDR[i], 20'd0);
        check_val({tag, "_drv"}, Data_drv[i], 16'd0);
        check_val({tag, "_acks"}, {A_ack[i], B_ack[i]}, 2'b00);
        check_val({tag, "_rdata"}, {A_rdata[i], B_rdata[i]}, 32'd0);
        check_val({tag, "_busy"}, busy[i], 1'b0);
    endtask

    task automatic assert_reset(string tag);
        Reset = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            A_req[i] = 1'b0;
            B_req[i] = 1'b0;
            mdl_rd[i][0] = 16'd0;
            mdl_rd[i][1] = 16'd0;
        end
        sbq.delete();
        qa.delete();
        qb.delete();
        #1;
        for (int i = 0; i < c_N; i++) check_idle(i, tag);
    endtask

    task automatic release_reset();
        @(negedge Clk);
        #2 Reset = 1'b1;
    endtask

    task automatic push_exp(int i, bit p, bit rd, logic [19:0] addr,
                            logic [15:0] wdata, logic [15:0] rdata, int c);
        exp_t e;
        e.inst = i; e.port = p; e.rd = rd; e.addr = addr;
        e.wdata = wdata; e.rdata = rdata; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic add_op(bit p, bit we, logic [19:0] addr, logic [15:0] wdata);
        op_t o;
        o.we = we; o.addr = addr; o.wdata = wdata;
        if (p) qb.push_back(o);
        else   qa.push_back(o);
    endtask

    task automatic load_port(int i, bit p, op_t o);
        if (p) begin
            B_we[i] = o.we; B_addr[i] = o.addr; B_wdata[i] = o.wdata; B_req[i] = 1'b1;
        end else begin
            A_we[i] = o.we; A_addr[i] = o.addr; A_wdata[i] = o.wdata; A_req[i] = 1'b1;
        end
    endtask

    // Requester model: holds req until ack, then loads the next queued op
    // (keeping req high) or drops req.
    task automatic run_ops(int i);
        bit a_on;
        bit b_on;
        int t;
        a_on = (qa.size() > 0);
        b_on = (qb.size() > 0);
        if (a_on) load_port(i, 1'b0, qa[0]);
        if (b_on) load_port(i, 1'b1, qb[0]);
        t = 0;
        while ((a_on || b_on) && t < 300) begin
            @(negedge Clk);
            t++;
            if (a_on && A_ack[i]) begin
                void'(qa.pop_front());
                if (qa.size() > 0) load_port(i, 1'b0, qa[0]);
                else begin A_req[i] = 1'b0; a_on = 1'b0; end
            end
            if (b_on && B_ack[i]) begin
                void'(qb.pop_front());
                if (qb.size() > 0) load_port(i, 1'b1, qb[0]);
                else begin B_req[i] = 1'b0; b_on = 1'b0; end
            end
        end
        check_val("ops_complete", {30'd0, a_on, b_on}, 32'd0);
        A_req[i] = 1'b0;
        B_req[i] = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    task automatic single(int i, bit p, bit we, logic [19:0] addr,
                          logic [15:0] wdata, logic [15:0] rdata);
        @(negedge Clk);
        push_exp(i, p, !we, addr, wdata, rdata, cyc + 2 + wc_of(i));
        add_op(p, we, addr, wdata);
        run_ops(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int w;
        for (int i = 0; i < c_N; i++) begin
            A_req[i] = 1'b0; A_we[i] = 1'b0; A_addr[i] = 20'd0; A_wdata[i] = 16'd0;
            B_req[i] = 1'b0; B_we[i] = 1'b0; B_addr[i] = 20'd0; B_wdata[i] = 16'd0;
            mdl_rd[i][0] = 16'd0;
            mdl_rd[i][1] = 16'd0;
        end
        w = wc_of(0);

        // Power-on reset values, during and after reset.
        repeat (2) @(negedge Clk);
        for (int i = 0; i < c_N; i++) check_idle(i, "por");
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        for (int i = 0; i < c_N; i++) check_idle(i, "post_por");

        // Single read on A; request fields are scrambled after grant.
        @(negedge Clk);
        k = cyc;
        push_exp(0, 1'b0, 1'b1, 20'h00123, 16'h0, 16'hBEEF, k + 2 + w);
        add_op(1'b0, 1'b0, 20'h00123, 16'h0);
        fork
            run_ops(0);
            begin
                repeat (2) @(negedge Clk);
                A_addr[0] = 20'h55555; A_we[0] = 1'b1; A_wdata[0] = 16'hFFFF;
            end
        join

        // Single write on B, then read it back through A.
        single(0, 1'b1, 1'b1, 20'h0FFFF, 16'h1234, 16'h0);
        single(0, 1'b0, 1'b0, 20'h0FFFF, 16'h0, 16'h1234);

        // Tie right after reset: A first, B 3+W cycles later.
        @(negedge Clk);
        #2 assert_reset("rst_tie");
        release_reset();
        @(negedge Clk);
        k = cyc;
        push_exp(0, 1'b0, 1'b0, 20'h00400, 16'hAAAA, 16'h0, k + 2 + w);
        push_exp(0, 1'b1, 1'b1, 20'h00123, 16'h0, 16'hBEEF, k + 5 + 2 * w);
        add_op(1'b0, 1'b1, 20'h00400, 16'hAAAA);
        add_op(1'b1, 1'b0, 20'h00123, 16'h0);
        run_ops(0);

        // Continuous contention: A, B, A, B with 3+W spacing.
        @(negedge Clk);
        k = cyc;
        push_exp(0, 1'b0, 1'b0, 20'h00200, 16'h1111, 16'h0,    k + 2 + w);
        push_exp(0, 1'b1, 1'b0, 20'h00300, 16'h2222, 16'h0,    k + 2 + w + (3 + w));
        push_exp(0, 1'b0, 1'b1, 20'h00300, 16'h0,    16'h2222, k + 2 + w + 2 * (3 + w));
        push_exp(0, 1'b1, 1'b1, 20'h00200, 16'h0,    16'h1111, k + 2 + w + 3 * (3 + w));
        add_op(1'b0, 1'b1, 20'h00200, 16'h1111);
        add_op(1'b0, 1'b0, 20'h00300, 16'h0);
        add_op(1'b1, 1'b1, 20'h00300, 16'h2222);
        add_op(1'b1, 1'b0, 20'h00200, 16'h0);
        run_ops(0);

        // Reset pulsed during the ACCESS phase of a write: no ack.
        @(negedge Clk);
        A_we[0] = 1'b1; A_addr[0] = 20'h00500; A_wdata[0] = 16'h7777; A_req[0] = 1'b1;
        repeat (2) @(negedge Clk);
        check_val("pre_rst_we", WE[0], 1'b0);
        #2 assert_reset("rst_mid");
        @(negedge Clk);
        check_val("rst_mid_no_ack", A_ack[0], 1'b0);
        #2 Reset = 1'b1;
        repeat (6) @(negedge Clk);
        check_val("rst_mid_idle", busy[0], 1'b0);

        // Tie after the mid-transaction reset: A wins again.
        @(negedge Clk);
        k = cyc;
        push_exp(0, 1'b0, 1'b1, 20'h00200, 16'h0, 16'h1111, k + 2 + w);
        push_exp(0, 1'b1, 1'b1, 20'h00300, 16'h0, 16'h2222, k + 5 + 2 * w);
        add_op(1'b0, 1'b0, 20'h00200, 16'h0);
        add_op(1'b1, 1'b0, 20'h00300, 16'h0);
        run_ops(0);

        // WAIT_CYCLES = 1 and 15.
        single(1, 1'b0, 1'b1, 20'h00600, 16'h5A5A, 16'h0);
        single(1, 1'b0, 1'b0, 20'h00600, 16'h0, 16'h5A5A);
        single(1, 1'b1, 1'b0, 20'h00123, 16'h0, 16'hBEEF);
        single(2, 1'b1, 1'b1, 20'h00700, 16'hC3C3, 16'h0);
        single(2, 1'b0, 1'b0, 20'h00700, 16'h0, 16'hC3C3);

        repeat (4) @(negedge Clk);
        check_val("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
